// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX pipeline register with operand select, forwarding and hazard stall
// Optional feature macro: EX_FORWARDING_EN (MEM/WB forwarding with load-use stall only).
// Without it, operands come straight from the captured register data and any pending writer stalls.
module ex_operand_stage #(
  parameter int WIDTH = 32,
  parameter int RAW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] id_pc,
  input  logic [WIDTH-1:0] id_rs1_data,
  input  logic [WIDTH-1:0] id_rs2_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [RAW-1:0]   id_rs1_addr,
  input  logic [RAW-1:0]   id_rs2_addr,
  input  logic [RAW-1:0]   id_rd_addr,
  input  logic [3:0]       id_alu_ctrl,
  input  logic             id_src_a,
  input  logic             id_src_b,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             out_ready,
  output logic             ex_valid,
  output logic [WIDTH-1:0] ex_a,
  output logic [WIDTH-1:0] ex_b,
  output logic [3:0]       ex_alu_ctrl,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [WIDTH-1:0] ex_pc,
  output logic [RAW-1:0]   ex_rd_addr,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  input  logic [RAW-1:0]   mem_rd_addr,
  input  logic [RAW-1:0]   wb_rd_addr,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  input  logic [WIDTH-1:0] mem_result,
  input  logic [WIDTH-1:0] wb_result
);

  logic [WIDTH-1:0] rs1_data_q;
  logic [WIDTH-1:0] rs2_data_q;
  logic [WIDTH-1:0] imm_q;
  logic [RAW-1:0]   rs1_addr_q;
  logic [RAW-1:0]   rs2_addr_q;
  logic             src_a_q;
  logic             src_b_q;
  logic             reg_write_q;
  logic             mem_read_q;

  logic [WIDTH-1:0] rs1_fwd;
  logic [WIDTH-1:0] rs2_fwd;
  logic             hazard;
  logic             load;

  assign ex_reg_write = reg_write_q & ex_valid;
  assign ex_mem_read  = mem_read_q & ex_valid;

`ifdef EX_FORWARDING_EN
  // Only a load in EX cannot be forwarded in time: its data is not ready until MEM completes.
  assign hazard = in_valid & ex_valid & mem_read_q & (ex_rd_addr != '0) &
                  ((ex_rd_addr == id_rs1_addr) | (ex_rd_addr == id_rs2_addr));

  // Forward the youngest producer: MEM overrides WB, WB overrides the captured register value.
  always_comb begin
    rs1_fwd = rs1_data_q;
    rs2_fwd = rs2_data_q;
    if (wb_reg_write && wb_rd_addr == rs1_addr_q && rs1_addr_q != '0)   rs1_fwd = wb_result;
    if (mem_reg_write && mem_rd_addr == rs1_addr_q && rs1_addr_q != '0) rs1_fwd = mem_result;
    if (wb_reg_write && wb_rd_addr == rs2_addr_q && rs2_addr_q != '0)   rs2_fwd = wb_result;
    if (mem_reg_write && mem_rd_addr == rs2_addr_q && rs2_addr_q != '0) rs2_fwd = mem_result;
  end
`else
  logic rs1_busy;
  logic rs2_busy;
  logic unused_nofwd;

  // Any in-flight writer of a nonzero source blocks issue until it has retired past WB.
  assign rs1_busy = (id_rs1_addr != '0) &
                    ((ex_reg_write & (ex_rd_addr == id_rs1_addr)) |
                     (mem_reg_write & (mem_rd_addr == id_rs1_addr)) |
                     (wb_reg_write & (wb_rd_addr == id_rs1_addr)));
  assign rs2_busy = (id_rs2_addr != '0) &
                    ((ex_reg_write & (ex_rd_addr == id_rs2_addr)) |
                     (mem_reg_write & (mem_rd_addr == id_rs2_addr)) |
                     (wb_reg_write & (wb_rd_addr == id_rs2_addr)));
  assign hazard = in_valid & (rs1_busy | rs2_busy);

  assign rs1_fwd = rs1_data_q;
  assign rs2_fwd = rs2_data_q;

  assign unused_nofwd = ^{mem_result, wb_result, rs1_addr_q, rs2_addr_q};
`endif

  assign in_ready      = (~ex_valid | out_ready) & ~hazard & ~flush;
  assign load          = in_valid & in_ready;

  assign ex_a          = src_a_q ? ex_pc : rs1_fwd;
  assign ex_b          = src_b_q ? imm_q : rs2_fwd;
  assign ex_store_data = rs2_fwd;

  // Stage register: reset > flush > load > drain > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      ex_rd_addr  <= '0;
      ex_alu_ctrl <= '0;
      src_a_q     <= 1'b0;
      src_b_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (load) begin
      ex_valid    <= 1'b1;
      ex_pc       <= id_pc;
      rs1_data_q  <= id_rs1_data;
      rs2_data_q  <= id_rs2_data;
      imm_q       <= id_imm;
      rs1_addr_q  <= id_rs1_addr;
      rs2_addr_q  <= id_rs2_addr;
      ex_rd_addr  <= id_rd_addr;
      ex_alu_ctrl <= id_alu_ctrl;
      src_a_q     <= id_src_a;
      src_b_q     <= id_src_b;
      reg_write_q <= id_reg_write;
      mem_read_q  <= id_mem_read;
    end else if (out_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - self-checking bench for ex_operand_stage with a reference model
module tb_ex_operand_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [3:0]  ctrl;
    logic        src_a;
    logic        src_b;
    logic        reg_write;
    logic        mem_read;
  } instr_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  instr_t      id;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_result;

  logic        in_ready, ex_valid, ex_reg_write, ex_mem_read;
  logic [31:0] ex_a, ex_b, ex_store_data, ex_pc;
  logic [3:0]  ex_alu_ctrl;
  logic [4:0]  ex_rd_addr;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state: is an instruction held, and which one
  logic   m_valid;
  instr_t m;

  always #5 clk = ~clk;

  ex_operand_stage #(.WIDTH(32), .RAW(5)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .id_pc(id.pc), .id_rs1_data(id.rs1_data), .id_rs2_data(id.rs2_data), .id_imm(id.imm),
    .id_rs1_addr(id.rs1_addr), .id_rs2_addr(id.rs2_addr), .id_rd_addr(id.rd_addr),
    .id_alu_ctrl(id.ctrl), .id_src_a(id.src_a), .id_src_b(id.src_b),
    .id_reg_write(id.reg_write), .id_mem_read(id.mem_read), .out_ready(out_ready),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd_addr(mem_rd_addr), .wb_rd_addr(wb_rd_addr),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .mem_result(mem_result), .wb_result(wb_result)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // value of a source register as the ALU should see it
  function automatic logic [31:0] exp_src(input logic [4:0] rs, input logic [31:0] captured);
`ifdef EX_FORWARDING_EN
    if (rs != 0 && mem_reg_write && mem_rd_addr == rs) return mem_result;
    if (rs != 0 && wb_reg_write && wb_rd_addr == rs) return wb_result;
`endif
    return captured;
  endfunction

  function automatic logic exp_hazard();
    logic [4:0] srcs[2];
    srcs[0] = id.rs1_addr;
    srcs[1] = id.rs2_addr;
    if (!in_valid) return 1'b0;
`ifdef EX_FORWARDING_EN
    if (!(m_valid && m.mem_read) || m.rd_addr == 0) return 1'b0;
    foreach (srcs[i]) if (srcs[i] == m.rd_addr) return 1'b1;
    return 1'b0;
`else
    begin
      logic [4:0] writers[$];
      if (m_valid && m.reg_write) writers.push_back(m.rd_addr);
      if (mem_reg_write) writers.push_back(mem_rd_addr);
      if (wb_reg_write) writers.push_back(wb_rd_addr);
      foreach (srcs[i])
        if (srcs[i] != 0)
          foreach (writers[j]) if (writers[j] == srcs[i]) return 1'b1;
      return 1'b0;
    end
`endif
  endfunction

  function automatic logic exp_ready();
    return (!m_valid || out_ready) && !exp_hazard() && !flush;
  endfunction

  // compare everything against the model, clock once, advance the model
  task automatic step();
    logic er;
    #1;
    er = exp_ready();
    check("in_ready", in_ready, er);
    check("ex_valid", ex_valid, m_valid);
    check("ex_reg_write", ex_reg_write, m_valid & m.reg_write);
    check("ex_mem_read", ex_mem_read, m_valid & m.mem_read);
    if (m_valid) begin
      check("ex_a", ex_a, m.src_a ? m.pc : exp_src(m.rs1_addr, m.rs1_data));
      check("ex_b", ex_b, m.src_b ? m.imm : exp_src(m.rs2_addr, m.rs2_data));
      check("ex_store_data", ex_store_data, exp_src(m.rs2_addr, m.rs2_data));
      check("ex_alu_ctrl", ex_alu_ctrl, m.ctrl);
      check("ex_pc", ex_pc, m.pc);
      check("ex_rd_addr", ex_rd_addr, m.rd_addr);
    end
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b0;
      m = '0;
    end else if (flush) m_valid = 1'b0;
    else if (in_valid && er) begin
      m = id;
      m_valid = 1'b1;
    end else if (out_ready) m_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_ports();
    mem_rd_addr = 0; wb_rd_addr = 0; mem_reg_write = 0; wb_reg_write = 0;
    mem_result = 0; wb_result = 0;
  endtask

  initial begin
    logic fwd_en;
`ifdef EX_FORWARDING_EN
    fwd_en = 1'b1;
`else
    fwd_en = 1'b0;
`endif
    reset = 1; flush = 0; in_valid = 0; out_ready = 0; id = '0;
    clear_ports();
    m_valid = 0; m = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    check("rst_valid", ex_valid, 0);
    check("rst_a", ex_a, 0);
    check("rst_b", ex_b, 0);
    check("rst_store", ex_store_data, 0);
    check("rst_pc", ex_pc, 0);
    check("rst_ctrl", ex_alu_ctrl, 0);
    check("rst_rd", ex_rd_addr, 0);
    check("rst_rw", ex_reg_write, 0);
    check("rst_mr", ex_mem_read, 0);
    check("rst_ready", in_ready, 1);

    // ADDI then backpressure
    id = '0; id.rs1_addr = 1; id.rs1_data = 5; id.imm = 7; id.src_b = 1; id.pc = 32'h10;
    in_valid = 1; out_ready = 1;
    step();
    in_valid = 0; out_ready = 0;
    #1;
    check("t1_valid", ex_valid, 1);
    check("t1_a", ex_a, 5);
    check("t1_b", ex_b, 7);
    check("t1_ctrl", ex_alu_ctrl, 0);
    id = '0; id.pc = 32'h100; in_valid = 1;
    repeat (3) begin
      #1;
      check("t2_ready", in_ready, 0);
      step();
      check("t2_hold_a", ex_a, 5);
      check("t2_hold_valid", ex_valid, 1);
    end
    in_valid = 0; out_ready = 1;
    step();
    check("t2_drain", ex_valid, 0);

    // forwarding priority on a held rs1=x3
    id = '0; id.rs1_addr = 3; id.rs1_data = 32'hAA; in_valid = 1; out_ready = 0;
    step();
    in_valid = 0;
    mem_rd_addr = 3; mem_reg_write = 1; mem_result = 32'h11;
    wb_rd_addr = 3; wb_reg_write = 1; wb_result = 32'h22;
    #1;
    check("t3_mem", ex_a, fwd_en ? 32'h11 : 32'hAA);
    step();
    mem_reg_write = 0;
    #1;
    check("t3_wb", ex_a, fwd_en ? 32'h22 : 32'hAA);
    step();
    clear_ports();
    id = '0; id.rs1_addr = 0; id.rs1_data = 32'h99; in_valid = 1; out_ready = 1;
    step();
    in_valid = 0; out_ready = 0;
    mem_rd_addr = 0; mem_reg_write = 1; mem_result = 32'h11;
    wb_rd_addr = 0; wb_reg_write = 1; wb_result = 32'h22;
    #1;
    check("t3_x0", ex_a, 32'h99);
    step();
    clear_ports();

    // load-use on x4
    id = '0; id.rd_addr = 4; id.reg_write = 1; id.mem_read = 1; in_valid = 1; out_ready = 1;
    step();
    id = '0; id.rs1_addr = 4; id.pc = 32'h40;
    #1;
    check("t4_stall", in_ready, 0);
    step();
    check("t4_bubble", ex_valid, 0);
    mem_rd_addr = 4; mem_reg_write = 1;
    #1;
    check("t4_mem", in_ready, fwd_en);
    step();
    mem_reg_write = 0; wb_rd_addr = 4; wb_reg_write = 1;
    #1;
    check("t4_wb", in_ready, fwd_en);
    step();
    wb_reg_write = 0;
    #1;
    check("t4_free", in_ready, 1);
    step();
    in_valid = 0;
    step();

    // flush with a full stage and a waiting instruction
    id = '0; id.pc = 32'h50; id.rd_addr = 5; id.reg_write = 1; in_valid = 1; out_ready = 0;
    step();
    id.pc = 32'h60; flush = 1;
    #1;
    check("t5_ready", in_ready, 0);
    step();
    flush = 0; in_valid = 0;
    #1;
    check("t5_empty", ex_valid, 0);
    step();

    // reset during a stall
    id = '0; id.pc = 32'h70; id.rd_addr = 6; id.reg_write = 1; in_valid = 1; out_ready = 0;
    step();
    id = '0; id.rs1_addr = 6; id.pc = 32'h74;
    step();
    reset = 1;
    step();
    reset = 0;
    #1;
    check("t6_valid", ex_valid, 0);
    check("t6_rw", ex_reg_write, 0);
    check("t6_ready", in_ready, 1);
    in_valid = 0;
    step();

    // randomized traffic over a small register window to provoke matches
    repeat (600) begin
      reset     = ($urandom % 60) == 0;
      flush     = ($urandom % 12) == 0;
      in_valid  = $urandom % 2;
      out_ready = ($urandom % 4) != 0;
      id.pc = $urandom; id.rs1_data = $urandom; id.rs2_data = $urandom; id.imm = $urandom;
      id.rs1_addr = $urandom % 4; id.rs2_addr = $urandom % 4; id.rd_addr = $urandom % 4;
      id.ctrl = $urandom; id.src_a = $urandom; id.src_b = $urandom;
      id.reg_write = $urandom; id.mem_read = $urandom;
      mem_rd_addr = $urandom % 4; wb_rd_addr = $urandom % 4;
      mem_reg_write = $urandom; wb_reg_write = $urandom;
      mem_result = $urandom; wb_result = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
